// File: rtl/stdp_sched_pkg.sv
// Shared types and defaults for the STDP update scheduler.
package stdp_sched_pkg;
  localparam int unsigned N_SYN_DEF    = 4;
  localparam int unsigned TICK_DIV_DEF = 6250;

  typedef enum logic [1:0] {
    OP_DECAY = 2'd0,
    OP_PRE   = 2'd1,
    OP_POST  = 2'd2
  } upd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } sched_state_e;
endpackage

// File: rtl/stdp_update_scheduler_if.sv
// Update-command channel between the scheduler (master) and the update engine (slave).
interface stdp_update_scheduler_if #(parameter int IDX_W = 2);
  logic             upd_valid;
  logic             upd_ready;
  logic [IDX_W-1:0] upd_idx;
  logic [1:0]       upd_op;
  logic             upd_last;

  modport master (output upd_valid, upd_idx, upd_op, upd_last, input upd_ready);
  modport slave  (input upd_valid, upd_idx, upd_op, upd_last, output upd_ready);
endinterface

// File: rtl/stdp_edge_detect.sv
// One-bit rising-edge detector; STDP_SCHED_SYNC_EN adds a two-flop synchronizer in front.
module stdp_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic smp;
  logic prev_q, prev_d;

`ifdef STDP_SCHED_SYNC_EN
  logic s1_q, s1_d, s2_q, s2_d;
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end
  // Reset high so a line already asserted at reset does not look like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end
  assign smp = s2_q;
`else
  assign smp = d;
`endif

  assign prev_d = smp;
  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b1;
    else       prev_q <= prev_d;
  end

  assign rise = smp & ~prev_q;
endmodule

// File: rtl/stdp_update_scheduler.sv
// Per-tick sweep scheduler issuing DECAY/PRE/POST commands to a shared STDP update engine.
// Optional input synchronizers: define STDP_SCHED_SYNC_EN.
module stdp_update_scheduler
  import stdp_sched_pkg::*;
#(
  parameter int N_SYN    = N_SYN_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int IDX_W    = (N_SYN > 1) ? $clog2(N_SYN) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [N_SYN-1:0]         pre_spike,
  input  logic [N_SYN-1:0]         post_spike,
  output logic                     tick,
  output logic                     busy,
  output logic                     overrun,
  stdp_update_scheduler_if.master  upd
);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [N_SYN-1:0] pre_rise, post_rise, pre_ev, post_ev;

  for (genvar g = 0; g < N_SYN; g++) begin : g_edge
    stdp_edge_detect u_pre  (.clk(clk), .reset(reset), .d(pre_spike[g]),  .rise(pre_rise[g]));
    stdp_edge_detect u_post (.clk(clk), .reset(reset), .d(post_spike[g]), .rise(post_rise[g]));
  end

  assign pre_ev  = enable ? pre_rise  : '0;
  assign post_ev = enable ? post_rise : '0;

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_SYN-1:0] pend_pre_q, pend_pre_d, pend_post_q, pend_post_d;
  logic [N_SYN-1:0] work_pre_q, work_pre_d, work_post_q, work_post_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             post_ph_q, post_ph_d;
  logic             overrun_q, overrun_d;

  logic    cnt_last, issuing, xfer, has_pre, has_post, split, idx_end, cur_last;
  upd_op_e cur_op;

  always_comb begin
    cnt_last = (cnt_q == CNT_W'(TICK_DIV - 1));
    tick     = enable & ~reset & cnt_last;
    issuing  = (state_q == ST_ISSUE);
    xfer     = issuing & upd.upd_ready;
    // post_ph marks that PRE of this index has already gone out.
    has_pre  = work_pre_q[idx_q] & ~post_ph_q;
    has_post = work_post_q[idx_q];
    split    = has_pre & has_post;
    idx_end  = (idx_q == IDX_W'(N_SYN - 1));
    cur_last = idx_end & ~split;
    cur_op   = has_pre ? OP_PRE : (has_post ? OP_POST : OP_DECAY);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_pre_d  = pend_pre_q | pre_ev;
    pend_post_d = pend_post_q | post_ev;
    work_pre_d  = work_pre_q;
    work_post_d = work_post_q;
    idx_d       = idx_q;
    post_ph_d   = post_ph_q;
    overrun_d   = overrun_q | (tick & (state_q != ST_IDLE));

    if (enable) cnt_d = cnt_last ? '0 : cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: if (tick) begin
        // Edges seen in the tick cycle belong to the next sweep.
        work_pre_d  = pend_pre_q;
        work_post_d = pend_post_q;
        pend_pre_d  = pre_ev;
        pend_post_d = post_ev;
        idx_d       = '0;
        post_ph_d   = 1'b0;
        state_d     = ST_ISSUE;
      end
      ST_ISSUE: if (xfer) begin
        if (split) begin
          post_ph_d = 1'b1;
        end else begin
          post_ph_d = 1'b0;
          if (idx_end) state_d = ST_DONE;
          else         idx_d   = idx_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pend_pre_q  <= '0;
      pend_post_q <= '0;
      work_pre_q  <= '0;
      work_post_q <= '0;
      idx_q       <= '0;
      post_ph_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_pre_q  <= pend_pre_d;
      pend_post_q <= pend_post_d;
      work_pre_q  <= work_pre_d;
      work_post_q <= work_post_d;
      idx_q       <= idx_d;
      post_ph_q   <= post_ph_d;
      overrun_q   <= overrun_d;
    end
  end

  assign upd.upd_valid = issuing;
  assign upd.upd_idx   = issuing ? idx_q : '0;
  assign upd.upd_op    = issuing ? cur_op : OP_DECAY;
  assign upd.upd_last  = issuing & cur_last;
  assign busy          = (state_q != ST_IDLE);
  assign overrun       = overrun_q;
endmodule

// File: tb/tb_stdp_update_scheduler.sv
// Randomized bench for stdp_update_scheduler against a queue-based sweep model.
module tb_stdp_update_scheduler;
  import stdp_sched_pkg::*;

  localparam int N  = 4;
  localparam int TD = 10;

  logic         clk = 1'b0;
  logic         reset, enable, tick, busy, overrun;
  logic [N-1:0] pre_spike, post_spike;

  stdp_update_scheduler_if #(.IDX_W(2)) u_if ();

  stdp_update_scheduler #(.N_SYN(N), .TICK_DIV(TD), .IDX_W(2)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .pre_spike(pre_spike), .post_spike(post_spike),
    .tick(tick), .busy(busy), .overrun(overrun), .upd(u_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d @%0t", tag, act, exp, $time);
    end
  endtask

  typedef struct {int idx; int op; bit last;} cmd_t;
  cmd_t     q[$];
  bit [N-1:0] m_prev_pre, m_prev_post, m_pend_pre, m_pend_post;
  int       m_cnt;
  bit       m_done, m_ovr;

  task automatic m_reset();
    q.delete();
    m_prev_pre  = '1;
    m_prev_post = '1;
    m_pend_pre  = '0;
    m_pend_post = '0;
    m_cnt  = 0;
    m_done = 0;
    m_ovr  = 0;
  endtask

  // Sweep from the spec rules: per index PRE, POST, or DECAY when neither.
  task automatic build_sweep(input bit [N-1:0] p, input bit [N-1:0] s);
    cmd_t c;
    for (int i = 0; i < N; i++) begin
      c.last = 0;
      c.idx  = i;
      if (p[i]) begin c.op = 1; q.push_back(c); end
      if (s[i]) begin c.op = 2; q.push_back(c); end
      if (!p[i] && !s[i]) begin c.op = 0; q.push_back(c); end
    end
    q[q.size()-1].last = 1;
  endtask

  task automatic m_step();
    bit [N-1:0] ev_pre, ev_post;
    bit idle, t, done_n;
    if (reset) begin m_reset(); return; end
    ev_pre  = enable ? (pre_spike  & ~m_prev_pre)  : '0;
    ev_post = enable ? (post_spike & ~m_prev_post) : '0;
    m_prev_pre  = pre_spike;
    m_prev_post = post_spike;
    idle = (q.size() == 0) && !m_done;
    t    = enable && (m_cnt == TD - 1);
    done_n = 0;
    if (q.size() > 0 && u_if.upd_ready) begin
      if (q[0].last) done_n = 1;
      void'(q.pop_front());
    end
    m_done = done_n;
    if (t && idle) begin
      build_sweep(m_pend_pre, m_pend_post);
      m_pend_pre  = ev_pre;
      m_pend_post = ev_post;
    end else begin
      if (t) m_ovr = 1;
      m_pend_pre  |= ev_pre;
      m_pend_post |= ev_post;
    end
    if (enable) m_cnt = (m_cnt == TD - 1) ? 0 : m_cnt + 1;
  endtask

  task automatic check_cycle();
    chk("tick",    tick,           (!reset && enable && m_cnt == TD - 1));
    chk("valid",   u_if.upd_valid, (q.size() > 0));
    chk("busy",    busy,           (q.size() > 0 || m_done));
    chk("overrun", overrun,        m_ovr);
    if (q.size() > 0) begin
      chk("idx",  u_if.upd_idx,  q[0].idx);
      chk("op",   u_if.upd_op,   q[0].op);
      chk("last", u_if.upd_last, q[0].last);
    end
  endtask

  task automatic drive(input int cyc);
    reset = 0;
    enable = 1;
    u_if.upd_ready = 1;
    if (cyc < 200) begin
      pre_spike  = '0;
      post_spike = '0;
      if (cyc >= 40 && cyc < 70) begin
        pre_spike[1]  = (cyc >= 42 && cyc < 45);
        post_spike[1] = (cyc >= 43 && cyc < 45);
        post_spike[3] = (cyc >= 45 && cyc < 48);
      end else if (cyc >= 70 && cyc < 100) begin
        u_if.upd_ready = !(cyc >= 71 && cyc < 76);
      end else if (cyc >= 100 && cyc < 140) begin
        u_if.upd_ready = !(cyc < 112);
        pre_spike[2]   = (cyc >= 103 && cyc < 106);
      end else if (cyc >= 140 && cyc < 170) begin
        pre_spike[0] = (cyc < 155) || (cyc >= 158);
        reset        = (cyc == 142 || cyc == 143);
      end else begin
        reset = (cyc == 176);
      end
    end else begin
      reset  = ($urandom_range(99) < 2);
      enable = ($urandom_range(99) < 92);
      u_if.upd_ready = ($urandom_range(99) < 70);
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(5) == 0) pre_spike[k]  = ~pre_spike[k];
        if ($urandom_range(5) == 0) post_spike[k] = ~post_spike[k];
      end
    end
  endtask

  initial begin
    reset = 1;
    enable = 1;
    pre_spike = '0;
    post_spike = '0;
    u_if.upd_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tick",    tick,           0);
    chk("rst_valid",   u_if.upd_valid, 0);
    chk("rst_idx",     u_if.upd_idx,   0);
    chk("rst_op",      u_if.upd_op,    0);
    chk("rst_last",    u_if.upd_last,  0);
    chk("rst_busy",    busy,           0);
    chk("rst_overrun", overrun,        0);
    m_reset();
    for (int cyc = 0; cyc < 1200; cyc++) begin
      @(negedge clk);
      drive(cyc);
      #1;
      check_cycle();
      m_step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stdp_update_scheduler.md
STDP_UPDATE_SCHEDULER -- requirements
Module: stdp_update_scheduler

Interface
REQ-001 Parameter N_SYN, 4, number of synapses sharing one trace/weight update engine.
REQ-002 Parameter TICK_DIV, 6250, clk cycles per STDP tick (1 ms).
REQ-003 Parameter IDX_W, $clog2(N_SYN) (minimum 1), width of synapse index.
REQ-004 clk  input  1  system clock.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 enable  input  1  run enable.
REQ-007 pre_spike  input  N_SYN  presynaptic spike levels, one bit per synapse.
REQ-008 post_spike  input  N_SYN  postsynaptic spike levels, one bit per synapse.
REQ-009 tick  output  1  one-cycle pulse per STDP tick.
REQ-010 upd_valid  output  1  update command valid.
REQ-011 upd_ready  input  1  update engine accepts command.
REQ-012 upd_idx  output  IDX_W  target synapse of the command.
REQ-013 upd_op  output  2  command: 0 DECAY, 1 PRE, 2 POST; 3 never driven.
REQ-014 upd_last  output  1  command is the final one of the current sweep.
REQ-015 busy  output  1  sweep in progress.
REQ-016 overrun  output  1  sticky flag: a tick arrived while busy.

Function
REQ-017 Tick counter counts 0..TICK_DIV-1 while enable=1; tick=1 exactly on the cycle the counter equals TICK_DIV-1, then the counter wraps to 0.
REQ-018 enable=0: counter holds, no tick, no new edge capture; any sweep in progress completes normally.
REQ-019 Rising edge = current sample 1 and previous sample 0; previous samples reset to 1, so an input already high at reset is not an edge.
REQ-020 Each edge sets pending_pre[i] / pending_post[i]; repeated edges before the next tick collapse into one event.
REQ-021 On tick with FSM in IDLE: pending bits are copied into work bits and cleared on the same edge; an edge arriving in the tick cycle lands in the new pending set.
REQ-022 FSM states: IDLE, ISSUE, DONE; IDLE->ISSUE on an accepted tick, ISSUE->DONE on the handshake of the upd_last command, DONE->IDLE unconditionally after one cycle.
REQ-023 upd_valid rises the cycle after the accepted tick; busy=1 in ISSUE and DONE.
REQ-024 Sweep visits idx 0..N_SYN-1 in ascending order: PRE if work_pre, then POST if work_post (both issued, PRE first, when both set), DECAY only if neither is set.
REQ-025 Handshake: a command transfers when upd_valid and upd_ready are both 1; upd_idx/upd_op/upd_last stay stable while upd_valid=1 and upd_ready=0; the next command is presented the following cycle (back-to-back, one command per cycle max).
REQ-026 upd_last=1 only on the final command of the last synapse index.
REQ-027 Tick while busy: overrun set, tick not accepted, pending retained and accumulating until the next tick seen in IDLE.
REQ-028 Sweep length is N_SYN + (count of synapses with both events) commands.

Reset
REQ-029 Reset clears counter, pending, work, and FSM (IDLE); tick, upd_valid, upd_idx, upd_op, upd_last, busy, overrun = 0.
REQ-030 Reset mid-sweep aborts the sweep without completion; upd_valid is 0 from the cycle after reset is sampled.

Configuration
REQ-031 Macro STDP_SCHED_SYNC_EN: when defined, each spike input passes through a two-flop synchronizer (reset value 1) ahead of edge detection, adding 2 cycles of capture latency; when undefined, inputs are sampled directly with a single register.

Structure
REQ-032 Package stdp_sched_pkg holds the upd_op encoding (DECAY/PRE/POST), the FSM state type, and the default TICK_DIV/N_SYN constants.
REQ-033 Sub-module stdp_edge_detect: one-bit optional synchronizer plus rising-edge detector, instantiated 2*N_SYN times.

Verification (N_SYN=4, TICK_DIV=10, upd_ready=1 unless stated)
REQ-034 Idle, no spikes -> tick every 10 cycles; each sweep issues DECAY idx 0,1,2,3, upd_last on idx 3.
REQ-035 pre_spike[1] edge, post_spike[1] edge, post_spike[3] edge before the tick -> commands DECAY0, PRE1, POST1, DECAY2, POST3 (last).
REQ-036 upd_ready low for 5 cycles on the 2nd command -> payload held stable, no command lost or duplicated, sweep ends 5 cycles later.
REQ-037 upd_ready=0 for 12 cycles -> the tick during the stall sets overrun=1; pending edges captured then are issued in the following sweep.
REQ-038 pre_spike[0] held high through reset -> no PRE for idx 0; a later 0->1 transition -> PRE0 in the next sweep.
REQ-039 Reset asserted on the 3rd command -> upd_valid=0 the next cycle, busy=0, overrun=0, next sweep starts after 10 counter cycles.
